message_stream_splitter: RTL and testbench
==========================================

// Module: message_stream_splitter
// PURPOSE
//  Demultiplexes one message stream into N_STREAMS output message streams, packet-atomically.
//  Each header carries a destination index. The header and its payload go, unchanged, to that output.
//  Sits upstream of per-lane consumers; its outputs can feed message_stream_combiner inputs.
//  Word format: bit WIDTH-1 = header flag.
//  Bits [WIDTH-2 -: LOG_MAX_PACKET_LENGTH] = payload length L.
//  Bits [WIDTH-2-LOG_MAX_PACKET_LENGTH -: LOG_N_STREAMS] = destination D.
// PARAMETERS
//  N_STREAMS             4    number of output streams
//  LOG_N_STREAMS         2    width of the destination field; 2**LOG_N_STREAMS >= N_STREAMS
//  WIDTH                 32   message word width
//  MAX_PACKET_LENGTH     1024 payload words per packet (exclusive bound)
//  LOG_MAX_PACKET_LENGTH 10   width of the length field; must satisfy 1+LOG_MAX_PACKET_LENGTH+LOG_N_STREAMS <= WIDTH
// PORTS
//  clk       in   1                  clock; all logic on posedge
//  rst_n     in   1                  synchronous, active-low reset
//  in_data   in   WIDTH              input message word
//  in_nd     in   1                  in_data valid this cycle; no backpressure
//  out_data  out  WIDTH*N_STREAMS    stream i occupies [WIDTH*(i+1)-1 -: WIDTH]
//  out_nd    out  N_STREAMS          per-stream valid; one-hot or zero
//  error     out  1                  sticky protocol error flag
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out_data=0, out_nd=0, error=0, state=HEADER, remaining=0, dest=0.
//    A reset mid-packet abandons the packet. The next accepted word is treated as a header.
//  Latency: a word accepted at cycle t appears on out_data slice D with out_nd[D]=1 at cycle t+1.
//    Throughput is one word per clock.
//  out_nd is registered and deasserts on any cycle with no forwarded word.
//    out_data slices hold their last value; only slice D is written.
//  FSM states: HEADER, BODY, DROP. Registers: remaining [LOG_MAX_PACKET_LENGTH], dest [LOG_N_STREAMS].
//  in_nd=0: no state change in any state.
//  HEADER, in_nd=1, flag=0: word dropped; error<=1; stay in HEADER.
//  HEADER, in_nd=1, flag=1, D<N_STREAMS: forward the header to D; dest<=D.
//    If L!=0: remaining<=L, go to BODY. If L==0: stay in HEADER (header-only packet).
//  HEADER, in_nd=1, flag=1, D>=N_STREAMS: header dropped; error<=1.
//    If L!=0: remaining<=L, go to DROP. If L==0: stay in HEADER.
//  BODY, in_nd=1: forward the word to dest with no inspection (flag bit ignored); remaining<=remaining-1.
//    Go to HEADER when remaining==1.
//  DROP, in_nd=1: discard the word; remaining<=remaining-1; go to HEADER when remaining==1.
//  Back-to-back packets: the header may arrive in the cycle right after the last payload word, with no gap.
//  error stays set until reset; forwarding continues after an error.
//  L is unsigned; L = 2**LOG_MAX_PACKET_LENGTH-1 is legal. The remaining counter never wraps.
// STRUCTURE
//  Shared include message_stream.vh holds the field-offset functions/macros:
//    header flag bit, length field MSB, destination field MSB.
//    Shared with message_stream_combiner so both blocks agree on the format.
//  The FSM state encodings are localparams in this module.
//  One sub-module, message_header_parse (combinational).
//    Inputs: word. Outputs: is_header, length, dest, dest_valid (D<N_STREAMS).
//  The top level contains the FSM, the counter and the output registers. No buffering.
// TESTING  (WIDTH=32, LOG_MAX_PACKET_LENGTH=10, LOG_N_STREAMS=2; header = 1<<31 | L<<21 | D<<19)
//  1. Header 0x80B00000 (L=5, D=2) then 5 data words 1..5, contiguous.
//     -> out_nd=4'b0100 for 6 consecutive cycles starting 1 cycle later; slice 2 = 0x80B00000,1,2,3,4,5; error=0.
//  2. Zero-length header 0x80080000 (D=1), then header 0x80200000 (L=1, D=0) + word 0xAB.
//     -> out_nd 0010, 0001, 0001; no stall.
//  3. Bare data word 0x00000007 while in HEADER.
//     -> no out_nd pulse; error=1 and stays set; a following valid packet is still forwarded.
//  4. N_STREAMS=3: header 0x80580000 (L=2, D=3) + 2 words, then header 0x80200000 + 0xCD.
//     -> first 3 words dropped, error=1; 0x80200000 and 0xCD appear on slice 0.
//  5. rst_n low for 1 cycle after word 2 of an L=5 packet.
//     -> all outputs 0; the next word 0x80200000 is parsed as a header and forwarded to slice 0.
//  6. in_nd gaps: L=3 packet with idle cycles between words.
//     -> words forwarded in order; out_nd=0 on gap cycles; packet completes after the 3rd word.

Source files
------------

// File: rtl/message_stream_splitter_pkg.sv
// Shared message-word format helpers and FSM sizing for the message stream blocks.
// The combiner imports the same offsets, so both blocks agree on where each field sits.
package message_stream_splitter_pkg;

  localparam int STATE_W = 2;

  function automatic int ms_flag_bit(input int width);
    return width - 1;
  endfunction

  function automatic int ms_len_msb(input int width);
    return width - 2;
  endfunction

  function automatic int ms_dest_msb(input int width, input int log_len);
    return width - 2 - log_len;
  endfunction

endpackage

// File: rtl/message_header_parse.sv
// Combinational field extraction for one message word: header flag, length, destination.
module message_header_parse
  import message_stream_splitter_pkg::*;
#(
  parameter int N_STREAMS             = 4,
  parameter int LOG_N_STREAMS         = 2,
  parameter int WIDTH                 = 32,
  parameter int LOG_MAX_PACKET_LENGTH = 10
) (
  input  logic [WIDTH-1:0]                 word,
  output logic                             is_header,
  output logic [LOG_MAX_PACKET_LENGTH-1:0] length,
  output logic [LOG_N_STREAMS-1:0]         dest,
  output logic                             dest_valid
);

  // One extra bit so N_STREAMS == 2**LOG_N_STREAMS is representable.
  localparam logic [LOG_N_STREAMS:0] N_LIMIT = (LOG_N_STREAMS+1)'(N_STREAMS);

  logic w_unused;

  assign is_header  = word[ms_flag_bit(WIDTH)];
  assign length     = word[ms_len_msb(WIDTH) -: LOG_MAX_PACKET_LENGTH];
  assign dest       = word[ms_dest_msb(WIDTH, LOG_MAX_PACKET_LENGTH) -: LOG_N_STREAMS];
  assign dest_valid = ({1'b0, dest} < N_LIMIT);
  assign w_unused   = ^word;

endmodule

// File: rtl/message_stream_splitter.sv
// Packet-atomic demultiplexer: routes each header and its payload to the output lane named
// in the header; bad headers and stray data words are discarded and latch a sticky error.
module message_stream_splitter
  import message_stream_splitter_pkg::*;
#(
  parameter int N_STREAMS             = 4,
  parameter int LOG_N_STREAMS         = 2,
  parameter int WIDTH                 = 32,
  parameter int MAX_PACKET_LENGTH     = 1024,
  parameter int LOG_MAX_PACKET_LENGTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_nd,
  output logic [WIDTH*N_STREAMS-1:0] out_data,
  output logic [N_STREAMS-1:0]       out_nd,
  output logic                       error
);

  localparam logic [STATE_W-1:0] S_HEADER = 2'd0;
  localparam logic [STATE_W-1:0] S_BODY   = 2'd1;
  localparam logic [STATE_W-1:0] S_DROP   = 2'd2;
  localparam logic [LOG_MAX_PACKET_LENGTH-1:0] LEN_ONE = 1;

  typedef enum logic [STATE_W-1:0] {
    HEADER = S_HEADER,
    BODY   = S_BODY,
    DROP   = S_DROP
  } state_t;

  if ((MAX_PACKET_LENGTH > (1 << LOG_MAX_PACKET_LENGTH)) ||
      (1 + LOG_MAX_PACKET_LENGTH + LOG_N_STREAMS > WIDTH) ||
      ((1 << LOG_N_STREAMS) < N_STREAMS)) begin : g_bad_cfg
    $error("message_stream_splitter: inconsistent field widths");
  end

  state_t                           r_state;
  logic [LOG_MAX_PACKET_LENGTH-1:0] r_remaining;
  logic [LOG_N_STREAMS-1:0]         r_dest;
  logic                             r_error;
  logic [N_STREAMS-1:0]             r_out_nd;
  logic [WIDTH-1:0]                 r_out_data [N_STREAMS];

  logic                             w_is_header;
  logic [LOG_MAX_PACKET_LENGTH-1:0] w_len;
  logic [LOG_N_STREAMS-1:0]         w_dest;
  logic                             w_dest_valid;

  message_header_parse #(
    .N_STREAMS            (N_STREAMS),
    .LOG_N_STREAMS        (LOG_N_STREAMS),
    .WIDTH                (WIDTH),
    .LOG_MAX_PACKET_LENGTH(LOG_MAX_PACKET_LENGTH)
  ) u_parse (
    .word      (in_data),
    .is_header (w_is_header),
    .length    (w_len),
    .dest      (w_dest),
    .dest_valid(w_dest_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= HEADER;
      r_remaining <= '0;
      r_dest      <= '0;
      r_error     <= 1'b0;
      r_out_nd    <= '0;
      for (int i = 0; i < N_STREAMS; i++) r_out_data[i] <= '0;
    end else begin
      r_out_nd <= '0;
      if (in_nd) begin
        case (r_state)
          HEADER: begin
            if (!w_is_header) begin
              r_error <= 1'b1;
            end else begin
              if (w_dest_valid) begin
                r_out_data[w_dest] <= in_data;
                r_out_nd[w_dest]   <= 1'b1;
                r_dest             <= w_dest;
              end else begin
                r_error <= 1'b1;
              end
              // Zero-length packets finish on the header itself.
              if (w_len != '0) begin
                r_remaining <= w_len;
                r_state     <= w_dest_valid ? BODY : DROP;
              end
            end
          end
          BODY: begin
            r_out_data[r_dest] <= in_data;
            r_out_nd[r_dest]   <= 1'b1;
            r_remaining        <= r_remaining - LEN_ONE;
            if (r_remaining == LEN_ONE) r_state <= HEADER;
          end
          DROP: begin
            r_remaining <= r_remaining - LEN_ONE;
            if (r_remaining == LEN_ONE) r_state <= HEADER;
          end
          default: r_state <= HEADER;
        endcase
      end
    end
  end

  for (genvar g = 0; g < N_STREAMS; g++) begin : g_out
    assign out_data[WIDTH*(g+1)-1 -: WIDTH] = r_out_data[g];
  end
  assign out_nd = r_out_nd;
  assign error  = r_error;

endmodule

// File: tb/tb_message_stream_splitter.sv
// Scoreboard bench: one 4-lane and one 3-lane splitter share a random/directed stream;
// a packet-level reference model predicts every cycle's outputs for each instance.
module tb_message_stream_splitter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_nd = 1'b0;
  logic [31:0]  in_data = '0;
  logic [127:0] od0;
  logic [3:0]   nd0;
  logic         err0;
  logic [95:0]  od1;
  logic [2:0]   nd1;
  logic         err1;

  always #5 clk = ~clk;

  message_stream_splitter #(.N_STREAMS(4), .LOG_N_STREAMS(2), .WIDTH(32),
    .MAX_PACKET_LENGTH(1024), .LOG_MAX_PACKET_LENGTH(10)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd),
    .out_data(od0), .out_nd(nd0), .error(err0));

  message_stream_splitter #(.N_STREAMS(3), .LOG_N_STREAMS(2), .WIDTH(32),
    .MAX_PACKET_LENGTH(1024), .LOG_MAX_PACKET_LENGTH(10)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd),
    .out_data(od1), .out_nd(nd1), .error(err1));

  typedef struct {
    logic [127:0] data;
    logic [3:0]   nd;
    logic         err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  int          nstr[2] = '{4, 3};
  int          m_rem[2];
  bit          m_drop[2];
  int          m_dest[2];
  bit          m_err[2];
  logic [31:0] m_sl[2][4];

  // Packet-level model: m_rem==0 means the next accepted word must be a header.
  function automatic void model(int k, bit rst, bit nd, logic [31:0] w);
    exp_t e;
    int   len, d;
    e.nd = '0;
    if (rst) begin
      m_rem[k] = 0; m_drop[k] = 0; m_dest[k] = 0; m_err[k] = 0;
      for (int i = 0; i < 4; i++) m_sl[k][i] = '0;
    end else if (nd) begin
      if (m_rem[k] == 0) begin
        len = int'(w[30:21]);
        d   = int'(w[20:19]);
        if (!w[31]) m_err[k] = 1;
        else begin
          m_rem[k] = len;
          if (d < nstr[k]) begin
            m_drop[k] = 0; m_dest[k] = d; m_sl[k][d] = w; e.nd[d] = 1'b1;
          end else begin
            m_drop[k] = 1; m_err[k] = 1;
          end
        end
      end else begin
        m_rem[k]--;
        if (!m_drop[k]) begin
          m_sl[k][m_dest[k]] = w; e.nd[m_dest[k]] = 1'b1;
        end
      end
    end
    e.err  = m_err[k];
    e.data = '0;
    for (int i = 0; i < nstr[k]; i++) e.data[32*i +: 32] = m_sl[k][i];
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  task automatic cmp(input string name, input int k, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", name, k, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin : mon0
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp("out_nd",   0, {124'b0, nd0},  {124'b0, e.nd});
      cmp("out_data", 0, od0,            e.data);
      cmp("error",    0, {127'b0, err0}, {127'b0, e.err});
    end
  end

  always @(posedge clk) begin : mon1
    exp_t e;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("out_nd",   1, {125'b0, nd1},       {124'b0, e.nd});
      cmp("out_data", 1, {32'b0, od1},        e.data);
      cmp("error",    1, {127'b0, err1},      {127'b0, e.err});
    end
  end

  task automatic step(input bit r, input bit nd, input logic [31:0] w);
    @(negedge clk);
    rst_n   = ~r;
    in_nd   = nd;
    in_data = w;
    model(0, r, nd, w);
    model(1, r, nd, w);
  endtask

  task automatic send(input logic [31:0] w);
    step(1'b0, 1'b1, w);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] hdr(input int len, input int d);
    return 32'h8000_0000 | (32'(len) << 21) | (32'(d) << 19);
  endfunction

  initial begin
    logic [31:0] w;
    int          len;

    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    idle();

    // Five-word packet to lane 2, contiguous.
    send(32'h80B0_0000);
    for (int i = 1; i <= 5; i++) send(32'(i));
    idle();

    // Header-only packet, then a one-word packet, back to back.
    send(32'h8008_0000);
    send(32'h8020_0000);
    send(32'h0000_00AB);
    idle();
    @(posedge clk); #2;
    cmp("error_clean", 0, {127'b0, err0}, 128'd0);

    // Stray data word in header position, then a good packet.
    send(32'h0000_0007);
    send(32'h8020_0000);
    send(32'h0000_00EE);
    idle();
    @(posedge clk); #2;
    cmp("error_sticky", 0, {127'b0, err0}, 128'd1);

    // Destination 3: dropped by the 3-lane instance, forwarded by the 4-lane one.
    send(32'h8058_0000);
    send(32'h0000_0001);
    send(32'h0000_0002);
    send(32'h8020_0000);
    send(32'h0000_00CD);
    idle();

    // Reset in the middle of a packet; next word must be parsed as a header.
    send(32'h80A8_0000);
    send(32'h0000_0001);
    send(32'h0000_0002);
    step(1'b1, 1'b0, 32'h0);
    send(32'h8020_0000);
    send(32'h0000_0055);
    idle();

    // Idle gaps inside a packet.
    send(32'h8070_0000);
    idle();
    send(32'h0000_0011);
    idle(); idle();
    send(32'h0000_0022);
    idle();
    send(32'h0000_0033);
    idle();
    send(32'h8020_0000);
    send(32'h0000_0044);

    // Maximum length packet, followed immediately by another header.
    send(hdr(1023, 3));
    for (int i = 0; i < 1023; i++) send($urandom);
    send(hdr(1, 0));
    send(32'h0000_0099);
    idle();

    // Random mix of packets, stray words, gaps and resets.
    for (int p = 0; p < 300; p++) begin
      case ($urandom_range(0, 19))
        0: step(1'b1, 1'b0, 32'h0);
        1: begin
          w = $urandom;
          w[31] = 1'b0;
          send(w);
        end
        default: begin
          len = $urandom_range(0, 6);
          send(hdr(len, $urandom_range(0, 3)));
          for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send($urandom);
          end
        end
      endcase
      if ($urandom_range(0, 4) == 0) idle();
    end

    idle();
    idle();
    @(posedge clk); #3;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d/%0d pending expected=0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
